a_reg: RTL and testbench

8-bit accumulator ("A") register of the bus-based 8-bit CPU. It loads a value from the shared tri-state system bus and drives its contents back onto that bus on command. It also presents its contents continuously to the ALU/CPU datapath. It sits between the common data bus and the ALU's A operand input, and the controller sequences it through `a_in`/`a_out`.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/bus_tristate.sv | 13 +
 rtl/a_reg.sv | 59 +++++
 tb/tb_a_reg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-based 8-bit CPU datapath registers.
package cpu_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t A_RST_VAL = '0;

  // True when every bit of the word is clear; used for zero status flags.
  function automatic logic isZero(input data_t value);
    return (value == '0);
  endfunction

endpackage

// File: rtl/bus_tristate.sv
// Generic tri-state bus driver shared by the CPU bus registers.
// The caller folds every release condition (output enable, reset) into i_en.
module bus_tristate #(
  parameter int WIDTH = 8
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  inout  wire  [WIDTH-1:0] io_bus
);

  assign io_bus = i_en ? i_data : {WIDTH{1'bz}};

endmodule

// File: rtl/a_reg.sv
// Accumulator (A) register: loads from the shared tri-state bus, drives its
// contents back onto the bus on command, and feeds the ALU A operand.
// Optional status flags a_zero/a_neg are built only when the macro
// A_REG_STATUS_EN is defined.
module a_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH   = DATA_W,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(A_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] a_bus,
  output logic [WIDTH-1:0] a_cpu,
  input  logic             a_in,
  input  logic             a_out
`ifdef A_REG_STATUS_EN
  ,
  output logic             a_zero,
  output logic             a_neg
`endif
);

  logic [WIDTH-1:0] r_aQ;
  logic             w_busEn;
  logic             w_load;

  // A load is suppressed while we are driving the bus ourselves, so a
  // controller that raises both enables simply keeps the current value.
  assign w_load  = a_in && !a_out;

  // Reset (which is active high despite its name) always frees the bus.
  assign w_busEn = a_out && !rst_n;

  // Register update: reset wins, then a bus capture, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_aQ <= RST_VAL;
    end else if (w_load) begin
      r_aQ <= a_bus;
    end
  end

  assign a_cpu = r_aQ;

  bus_tristate #(
    .WIDTH (WIDTH)
  ) u_busDrv (
    .i_en   (w_busEn),
    .i_data (r_aQ),
    .io_bus (a_bus)
  );

`ifdef A_REG_STATUS_EN
  assign a_zero = (r_aQ == '0);
  assign a_neg  = r_aQ[WIDTH-1];
`endif

endmodule

// File: tb/tb_a_reg.sv
// Self-checking bench for a_reg: directed scenarios followed by randomized
// operations compared against a simple behavioural model of the register.
// Status flag checks are included when A_REG_STATUS_EN is defined.
module tb_a_reg;

  logic       clk;
  logic       rst_n;
  logic       a_in;
  logic       a_out;
  logic       tbDrvEn;
  logic [7:0] tbDrvVal;
  wire  [7:0] a_bus;
  logic [7:0] a_cpu;
`ifdef A_REG_STATUS_EN
  logic       a_zero;
  logic       a_neg;
`endif

  int compareCnt;
  int failCnt;
  logic [7:0] modelA;

  assign a_bus = tbDrvEn ? tbDrvVal : 8'bzzzz_zzzz;

  a_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_bus (a_bus),
    .a_cpu (a_cpu),
    .a_in  (a_in),
    .a_out (a_out)
`ifdef A_REG_STATUS_EN
    ,
    .a_zero(a_zero),
    .a_neg (a_neg)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkStatus(input string tag);
`ifdef A_REG_STATUS_EN
    checkOutput({tag, "_zero"}, {7'd0, a_zero}, {7'd0, (modelA == 8'h00)});
    checkOutput({tag, "_neg"},  {7'd0, a_neg},  {7'd0, modelA[7]});
`else
    checkOutput({tag, "_cpu2"}, a_cpu, modelA);
`endif
  endtask

  // Set up inputs just after a falling edge so they are stable at the next rise.
  task automatic applyStimulus(input logic rst, input logic ldEn, input logic outEn,
                               input logic drvEn, input logic [7:0] drvVal);
    @(negedge clk);
    rst_n    = rst;
    a_in     = ldEn;
    a_out    = outEn;
    tbDrvEn  = drvEn;
    tbDrvVal = drvVal;
    #1;
  endtask

  // Advance past the rising edge and update the model from the rules.
  task automatic clockEdge();
    @(posedge clk);
    if (rst_n)
      modelA = 8'h00;
    else if (a_in && !a_out)
      modelA = a_bus;
    #1;
  endtask

  initial begin
    compareCnt = 0;
    failCnt    = 0;
    modelA     = 8'h00;
    rst_n      = 1'b1;
    a_in       = 1'b0;
    a_out      = 1'b1;
    tbDrvEn    = 1'b1;
    tbDrvVal   = 8'h00;

    // Reset held three cycles with a_out high; bus must stay with the bench.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
      clockEdge();
      checkOutput("reset_cpu", a_cpu, 8'h00);
      checkOutput("reset_bus", a_bus, 8'h00);
      checkStatus("reset");
    end

    // Load 8'hAF from the bus.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hAF);
    clockEdge();
    checkOutput("load_cpu", a_cpu, 8'hAF);
    checkStatus("load");

    // Drive back: value appears combinationally, then released.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("drive_bus", a_bus, 8'hAF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("release_bus", a_bus, 8'h00);

    // Hold for two cycles while the bus shows 8'h33.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
      clockEdge();
      checkOutput("hold_cpu", a_cpu, 8'hAF);
    end

    // Both enables: hold value, keep driving.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("conflict_bus_pre", a_bus, 8'hAF);
    clockEdge();
    checkOutput("conflict_cpu", a_cpu, 8'hAF);
    checkOutput("conflict_bus_post", a_bus, 8'hAF);

    // Reset asserted with a_out high: bus released before the edge.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    checkOutput("rst_release_bus", a_bus, 8'h00);
    clockEdge();
    checkOutput("rst_release_cpu", a_cpu, 8'h00);

    // Reload, then reset in the same edge as a load of 8'h55.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h9C);
    clockEdge();
    checkOutput("reload_cpu", a_cpu, 8'h9C);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    clockEdge();
    checkOutput("rst_midload_cpu", a_cpu, 8'h00);
    checkStatus("rst_midload");

    // Randomized operations against the model.
    for (int i = 0; i < 200; i++) begin
      logic       rRst;
      logic       rIn;
      logic       rOut;
      logic [7:0] rVal;
      rRst = ($urandom_range(0, 9) == 0);
      rIn  = $urandom_range(0, 1) == 1;
      rOut = $urandom_range(0, 2) == 0;
      rVal = 8'($urandom);
      // The bench drives only when the register must not, avoiding contention.
      applyStimulus(rRst, rIn, rOut, !(rOut && !rRst), rVal);
      if (rOut && !rRst)
        checkOutput("rand_drive_bus", a_bus, modelA);
      else
        checkOutput("rand_release_bus", a_bus, rVal);
      clockEdge();
      checkOutput("rand_cpu", a_cpu, modelA);
      checkStatus("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule
